ap_ctrl_stat_monitor: RTL and testbench

Synthesizable, parametrised monitor for `ap_ctrl_chain` handshakes across `NUM_CH` HLS modules. It extends the simulation-only per-module status dump to on-chip statistics: transaction count, busy cycles, latency (last/min/max), `ap_continue` back-pressure stall cycles and `ap_ready` count per channel. It sits beside the kernel and taps each submodule's `ap_start`/`ap_ready`/`ap_done`/`ap_continue`. A host or testbench reads the statistics through a registered select/read port.

---
 rtl/ap_ctrl_stat_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_ap_ctrl_stat_monitor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_stat_monitor.sv
// Purpose : per-channel ap_ctrl_chain handshake statistics (count, busy, latency, stall, ready)
// Latency : statistics update one edge after the sampled handshake; reads return one cycle after rd_en
// Backpr. : passive tap, never stalls the monitored modules; one read accepted per cycle
//
// Ports:
//   clock, reset (async, active-high), clr (sync clear), finish (freeze)
//   ap_start/ap_ready/ap_done/ap_continue [NUM_CH] : tapped handshakes, bit i = channel i
//   rd_en, rd_ch, rd_sel  : read request, channel and field select
//   rd_valid, rd_data     : registered read response (data held until next read)
//   any_overflow          : registered OR of all sticky per-channel saturation flags
module ap_ctrl_stat_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  localparam int RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              finish,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_en,
  input  logic [RD_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              any_overflow
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUSY      = 2'd1,
    S_DONE_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAXV) ? v : v + ONE;
  endfunction

  // Current state / statistics
  state_t           r_state [NUM_CH];
  logic [CNT_W-1:0] r_lat   [NUM_CH];
  logic [CNT_W-1:0] r_count [NUM_CH];
  logic [CNT_W-1:0] r_busy  [NUM_CH];
  logic [CNT_W-1:0] r_last  [NUM_CH];
  logic [CNT_W-1:0] r_min   [NUM_CH];
  logic [CNT_W-1:0] r_max   [NUM_CH];
  logic [CNT_W-1:0] r_stall [NUM_CH];
  logic [CNT_W-1:0] r_rdy   [NUM_CH];
  logic [NUM_CH-1:0] r_ovf;

  // Next values
  state_t           w_state_n [NUM_CH];
  logic [CNT_W-1:0] w_lat_n   [NUM_CH];
  logic [CNT_W-1:0] w_count_n [NUM_CH];
  logic [CNT_W-1:0] w_busy_n  [NUM_CH];
  logic [CNT_W-1:0] w_last_n  [NUM_CH];
  logic [CNT_W-1:0] w_min_n   [NUM_CH];
  logic [CNT_W-1:0] w_max_n   [NUM_CH];
  logic [CNT_W-1:0] w_stall_n [NUM_CH];
  logic [CNT_W-1:0] w_rdy_n   [NUM_CH];
  logic [NUM_CH-1:0] w_ovf_n;

  logic              r_rd_valid;
  logic [CNT_W-1:0]  r_rd_data;
  logic              r_any_ovf;
  logic [CNT_W-1:0]  w_rd_field;

  // Next-state and statistic update for every channel
  always_comb begin
    logic [CNT_W-1:0] w_lat_v;
    logic             w_cmp;
    logic             w_sat;
    w_lat_v = '0;
    w_cmp   = 1'b0;
    w_sat   = 1'b0;
    w_ovf_n = r_ovf;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_n[i] = r_state[i];
      w_lat_n[i]   = r_lat[i];
      w_count_n[i] = r_count[i];
      w_busy_n[i]  = r_busy[i];
      w_last_n[i]  = r_last[i];
      w_min_n[i]   = r_min[i];
      w_max_n[i]   = r_max[i];
      w_stall_n[i] = r_stall[i];
      w_rdy_n[i]   = r_rdy[i];
      w_lat_v      = r_lat[i];
      w_cmp        = 1'b0;
      w_sat        = 1'b0;

      if (clr) begin
        // Clear beats any same-cycle start/done/ready event
        w_state_n[i] = S_IDLE;
        w_lat_n[i]   = '0;
        w_count_n[i] = '0;
        w_busy_n[i]  = '0;
        w_last_n[i]  = '0;
        w_min_n[i]   = MAXV;
        w_max_n[i]   = '0;
        w_stall_n[i] = '0;
        w_rdy_n[i]   = '0;
        w_ovf_n[i]   = 1'b0;
      end else if (!finish) begin
        if (ap_ready[i]) begin
          w_rdy_n[i] = sat_inc(r_rdy[i]);
          w_sat      = w_sat | (r_rdy[i] == MAXV);
        end

        unique case (r_state[i])
          S_IDLE: begin
            if (ap_start[i]) begin
              w_lat_v     = ONE;
              w_busy_n[i] = sat_inc(r_busy[i]);
              w_sat       = w_sat | (r_busy[i] == MAXV);
              if (ap_done[i]) w_cmp = 1'b1;
              else            w_state_n[i] = S_BUSY;
            end
          end
          S_BUSY: begin
            w_lat_v     = sat_inc(r_lat[i]);
            w_busy_n[i] = sat_inc(r_busy[i]);
            w_sat       = w_sat | (r_lat[i] == MAXV) | (r_busy[i] == MAXV);
            if (ap_done[i]) w_cmp = 1'b1;
          end
          S_DONE_WAIT: begin
            // Start is ignored until the consumer releases the output
            if (ap_continue[i]) begin
              w_state_n[i] = S_IDLE;
            end else begin
              w_stall_n[i] = sat_inc(r_stall[i]);
              w_sat        = w_sat | (r_stall[i] == MAXV);
            end
          end
          default: w_state_n[i] = S_IDLE;
        endcase

        w_lat_n[i] = w_lat_v;

        if (w_cmp) begin
          w_state_n[i] = ap_continue[i] ? S_IDLE : S_DONE_WAIT;
          w_count_n[i] = sat_inc(r_count[i]);
          w_sat        = w_sat | (r_count[i] == MAXV);
          w_last_n[i]  = w_lat_v;
          if (w_lat_v < r_min[i]) w_min_n[i] = w_lat_v;
          if (w_lat_v > r_max[i]) w_max_n[i] = w_lat_v;
        end

        if (w_sat) w_ovf_n[i] = 1'b1;
      end
    end
  end

  // State and statistic registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_lat[i]   <= '0;
        r_count[i] <= '0;
        r_busy[i]  <= '0;
        r_last[i]  <= '0;
        r_min[i]   <= MAXV;
        r_max[i]   <= '0;
        r_stall[i] <= '0;
        r_rdy[i]   <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_n[i];
        r_lat[i]   <= w_lat_n[i];
        r_count[i] <= w_count_n[i];
        r_busy[i]  <= w_busy_n[i];
        r_last[i]  <= w_last_n[i];
        r_min[i]   <= w_min_n[i];
        r_max[i]   <= w_max_n[i];
        r_stall[i] <= w_stall_n[i];
        r_rdy[i]   <= w_rdy_n[i];
      end
      r_ovf <= w_ovf_n;
    end
  end

  // Field select works on current (pre-update) register values
  always_comb begin
    w_rd_field = '0;
    if (int'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0: w_rd_field = r_count[rd_ch];
        3'd1: w_rd_field = r_busy[rd_ch];
        3'd2: w_rd_field = r_last[rd_ch];
        3'd3: w_rd_field = r_min[rd_ch];
        3'd4: w_rd_field = r_max[rd_ch];
        3'd5: w_rd_field = r_stall[rd_ch];
        3'd6: w_rd_field = r_rdy[rd_ch];
        default: w_rd_field = {{(CNT_W-3){1'b0}}, r_ovf[rd_ch], r_state[rd_ch]};
      endcase
    end
  end

  // Read port stays live under freeze and clear; data is held between reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_any_ovf  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_field;
      r_any_ovf  <= clr ? 1'b0 : (|r_ovf);
    end
  end

  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign any_overflow = r_any_ovf;

endmodule

// File: tb/tb_ap_ctrl_stat_monitor.sv
module tb_ap_ctrl_stat_monitor;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              clr = 1'b0;
  logic              finish = 1'b0;
  logic [NUM_CH-1:0] ap_start = '0;
  logic [NUM_CH-1:0] ap_ready = '0;
  logic [NUM_CH-1:0] ap_done = '0;
  logic [NUM_CH-1:0] ap_continue = '1;
  logic              rd_en = 1'b0;
  logic [1:0]        rd_ch = '0;
  logic [2:0]        rd_sel = '0;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              any_overflow;

  int checks = 0;
  int errors = 0;

  ap_ctrl_stat_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clr(clr), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .any_overflow(any_overflow)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one read, then check the response on the following cycle
  task automatic rd(input string tag, input logic [1:0] ch, input logic [2:0] sel,
                    input logic [31:0] exp);
    rd_en = 1'b1; rd_ch = ch; rd_sel = sel;
    step();
    rd_en = 1'b0;
    chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
    chk(tag, 32'(rd_data), exp);
  endtask

  // Transaction of the given latency with ap_continue held high
  task automatic txn(input int ch, input int lat);
    ap_start[ch] = 1'b1;
    if (lat == 1) ap_done[ch] = 1'b1;
    step();
    ap_start[ch] = 1'b0;
    ap_done[ch]  = 1'b0;
    if (lat > 1) begin
      repeat (lat - 2) step();
      ap_done[ch] = 1'b1;
      step();
      ap_done[ch] = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_any_ovf", 32'(any_overflow), 32'd0);
    rd("rst_min0", 2'd0, 3'd3, 32'd255);
    step();
    chk("rd_valid_pulse", 32'(rd_valid), 32'd0);
    chk("rd_data_hold", 32'(rd_data), 32'd255);
    rd("rst_stat2", 2'd2, 3'd7, 32'd0);

    // 1. Single transaction, latency 5 on ch0
    txn(0, 5);
    rd("t1_count", 2'd0, 3'd0, 32'd1);
    rd("t1_last", 2'd0, 3'd2, 32'd5);
    rd("t1_min", 2'd0, 3'd3, 32'd5);
    rd("t1_max", 2'd0, 3'd4, 32'd5);
    rd("t1_busy", 2'd0, 3'd1, 32'd5);
    rd("t1_stall", 2'd0, 3'd5, 32'd0);

    // 2. ch1 start+done same cycle, continue low for 3 cycles
    ap_start[1] = 1'b1; ap_done[1] = 1'b1; ap_continue[1] = 1'b0;
    step();
    ap_start[1] = 1'b0; ap_done[1] = 1'b0;
    rd("t2_stat_wait", 2'd1, 3'd7, 32'd2);
    repeat (2) step();
    ap_continue[1] = 1'b1;
    step();
    rd("t2_stat_idle", 2'd1, 3'd7, 32'd0);
    rd("t2_last", 2'd1, 3'd2, 32'd1);
    rd("t2_stall", 2'd1, 3'd5, 32'd3);
    rd("t2_count", 2'd1, 3'd0, 32'd1);

    // Ready counting independent of FSM state
    ap_ready[2] = 1'b1;
    repeat (2) step();
    ap_ready[2] = 1'b0;
    rd("rdy_cnt", 2'd2, 3'd6, 32'd2);

    // 3. ch2 latencies 7, 3, 9
    txn(2, 7);
    txn(2, 3);
    txn(2, 9);
    rd("t3_min", 2'd2, 3'd3, 32'd3);
    rd("t3_max", 2'd2, 3'd4, 32'd9);
    rd("t3_last", 2'd2, 3'd2, 32'd9);
    rd("t3_count", 2'd2, 3'd0, 32'd3);
    rd("t3_busy", 2'd2, 3'd1, 32'd19);

    // 5. Freeze and clear on ch1 (busy starts at 1)
    ap_start[1] = 1'b1;
    step();
    ap_start[1] = 1'b0;
    repeat (2) step();
    finish = 1'b1;
    ap_ready[1] = 1'b1;
    repeat (4) step();
    rd("t5_busy_frozen", 2'd1, 3'd1, 32'd4);
    rd("t5_rdy_frozen", 2'd1, 3'd6, 32'd0);
    ap_ready[1] = 1'b0;
    finish = 1'b0;
    step();
    rd("t5_busy_resume", 2'd1, 3'd1, 32'd5);
    clr = 1'b1; ap_done[1] = 1'b1;
    rd("t5_rd_preclr", 2'd1, 3'd1, 32'd6);
    clr = 1'b0; ap_done[1] = 1'b0;
    rd("t5_count", 2'd1, 3'd0, 32'd0);
    rd("t5_min", 2'd1, 3'd3, 32'd255);
    rd("t5_busy", 2'd1, 3'd1, 32'd0);
    rd("t5_stat", 2'd1, 3'd7, 32'd0);
    rd("t5_count2", 2'd2, 3'd0, 32'd0);

    // 4. Saturation on ch0
    ap_start[0] = 1'b1;
    step();
    ap_start[0] = 1'b0;
    repeat (254) step();
    chk("t4_aovf_pre", 32'(any_overflow), 32'd0);
    step();
    chk("t4_aovf_lag", 32'(any_overflow), 32'd0);
    step();
    chk("t4_aovf_set", 32'(any_overflow), 32'd1);
    repeat (43) step();
    rd("t4_stat", 2'd0, 3'd7, 32'd5);
    rd("t4_busy", 2'd0, 3'd1, 32'd255);
    ap_done[0] = 1'b1;
    step();
    ap_done[0] = 1'b0;
    rd("t4_last", 2'd0, 3'd2, 32'd255);
    rd("t4_max", 2'd0, 3'd4, 32'd255);
    rd("t4_count", 2'd0, 3'd0, 32'd1);
    rd("t4_stat_idle", 2'd0, 3'd7, 32'd4);

    // 6. Async reset between edges while channels are busy
    ap_start[0] = 1'b1; ap_start[1] = 1'b1;
    rd("t6_pre_count", 2'd0, 3'd0, 32'd1);
    ap_start[0] = 1'b0; ap_start[1] = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_rd_data", 32'(rd_data), 32'd0);
    chk("t6_any_ovf", 32'(any_overflow), 32'd0);
    #1 reset = 1'b0;
    step();
    rd("t6_stat0", 2'd0, 3'd7, 32'd0);
    rd("t6_stat1", 2'd1, 3'd7, 32'd0);
    rd("t6_count0", 2'd0, 3'd0, 32'd0);
    rd("t6_min0", 2'd0, 3'd3, 32'd255);
    rd("t6_oor", 2'd3, 3'd3, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
